// File: rtl/uart_buffered_if.sv
// uart_buffered_if: native CPU memory bus bundle for uart_buffered.
//   mem_valid  request from the master
//   mem_addr   byte address
//   mem_wstrb  write strobes, any bit set marks a write
//   mem_wdata  write data
//   mem_rdata  read data, valid while mem_ready is high
//   mem_ready  one-cycle completion pulse from the slave
interface uart_buffered_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/uart_buffered.sv
// uart_buffered: memory-mapped UART with TX/RX FIFOs, programmable baud
// divider and sticky overrun/framing (and optionally parity) error flags.
// Optional even parity is enabled by defining UART_BUFFERED_PARITY_EN.
// Ports:
//   clk     system clock
//   resetn  synchronous active-low reset
//   bus     memory bus slave (valid/ready, byte strobes), 256-byte window
//   tx      serial output, idle high
//   rx      serial input, asynchronous to clk
// Registers: 0x00 STATUS (W1C bits 2..4), 0x04 TXDATA, 0x08 RXDATA,
//            0x0C DIVIDER (clocks per bit, minimum 4).
module uart_buffered #(
  parameter logic [31:0] ADDR      = 32'h0000_0000,
  parameter real         CLK_FREQ  = 1e6,
  parameter real         BAUDRATE  = 115200,
  parameter int          DATA_BITS = 8,
  parameter int          STOP_BITS = 1,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16
) (
  input  logic            clk,
  input  logic            resetn,
  uart_buffered_if.slave  bus,
  output logic            tx,
  input  logic            rx
);

  localparam int          RST_DIV_I = $rtoi(CLK_FREQ / BAUDRATE + 0.5);
  localparam logic [15:0] RST_DIV   = 16'(RST_DIV_I);
  localparam int          TAW       = $clog2(TX_DEPTH);
  localparam int          RAW       = $clog2(RX_DEPTH);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // ---------------- bus decode ----------------
  logic       sel, accept, is_wr;
  logic [7:0] off;
  logic       wr_status, wr_tx, wr_div, rd_rx;
  logic [15:0] unused_wdata;

  assign sel       = bus.mem_valid && (bus.mem_addr[31:8] == ADDR[31:8]);
  assign accept    = sel && !bus.mem_ready;
  assign is_wr     = |bus.mem_wstrb;
  assign off       = bus.mem_addr[7:0];
  assign wr_status = accept && is_wr && (off == 8'h00);
  assign wr_tx     = accept && is_wr && (off == 8'h04);
  assign rd_rx     = accept && !is_wr && (off == 8'h08);
  assign wr_div    = accept && is_wr && (off == 8'h0C);
  assign unused_wdata = bus.mem_wdata[31:16];

  logic [15:0] divider;
  logic        overrun, framing_err;
`ifdef UART_BUFFERED_PARITY_EN
  logic        parity_err;
`endif

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TAW:0]         tx_wp, tx_rp;
  logic                 tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  assign tx_push  = wr_tx && (!tx_full || tx_pop);
  assign tx_head  = tx_mem[tx_rp[TAW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= bus.mem_wdata[DATA_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RAW:0]         rx_wp, rx_rp;
  logic                 rx_empty, rx_full, rx_push, rx_pop;
  logic [DATA_BITS-1:0] rx_head, rx_shift;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
  assign rx_pop   = rd_rx && !rx_empty;
  assign rx_head  = rx_mem[rx_rp[RAW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  // ---------------- TX shifter ----------------
  tx_state_t            tx_state;
  logic [16:0]          tx_cnt, tx_bit_len, tx_stop_len;
  logic [15:0]          tx_div;
  logic [DATA_BITS-1:0] tx_shift;
  logic [2:0]           tx_bit;
`ifdef UART_BUFFERED_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_bit_len  = {1'b0, tx_div} - 17'd1;
  assign tx_stop_len = (STOP_BITS == 2) ? {tx_div, 1'b0} - 17'd1 : tx_bit_len;
  // Pop happens both from IDLE and at the last STOP clock so frames chain with no gap.
  assign tx_pop = !tx_empty && ((tx_state == TX_IDLE) ||
                                (tx_state == TX_STOP && tx_cnt == '0));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_div   <= RST_DIV;
      tx_shift <= '0;
      tx_bit   <= '0;
`ifdef UART_BUFFERED_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE, TX_STOP: begin
          if (tx_state == TX_IDLE || tx_cnt == '0) begin
            if (!tx_empty) begin
              tx       <= 1'b0;
              tx_shift <= tx_head;
              tx_div   <= divider;
              tx_cnt   <= {1'b0, divider} - 17'd1;
              tx_state <= TX_START;
`ifdef UART_BUFFERED_PARITY_EN
              tx_par   <= ^tx_head;
`endif
            end else begin
              tx       <= 1'b1;
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 17'd1;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= '0;
            tx_cnt   <= tx_bit_len;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - 17'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            if (tx_bit == LAST_BIT) begin
`ifdef UART_BUFFERED_PARITY_EN
              tx       <= tx_par;
              tx_cnt   <= tx_bit_len;
              tx_state <= TX_PARITY;
`else
              tx       <= 1'b1;
              tx_cnt   <= tx_stop_len;
              tx_state <= TX_STOP;
`endif
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 3'd1;
              tx_cnt   <= tx_bit_len;
            end
          end else begin
            tx_cnt <= tx_cnt - 17'd1;
          end
        end
`ifdef UART_BUFFERED_PARITY_EN
        TX_PARITY: begin
          if (tx_cnt == '0) begin
            tx       <= 1'b1;
            tx_cnt   <= tx_stop_len;
            tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt - 17'd1;
          end
        end
`endif
        default: begin
          tx       <= 1'b1;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX sampler ----------------
  rx_state_t   rx_state;
  logic        rx_s1, rx_s2;
  logic [15:0] rx_cnt, rx_div;
  logic [2:0]  rx_bit;
  logic        stop_hit;
`ifdef UART_BUFFERED_PARITY_EN
  logic        rx_par_bit;
`endif

  assign stop_hit = (rx_state == RX_STOP) && (rx_cnt == '0);
  assign rx_push  = stop_hit && rx_s2 && (!rx_full || rx_pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= RST_DIV;
      rx_bit   <= '0;
      rx_shift <= '0;
`ifdef UART_BUFFERED_PARITY_EN
      rx_par_bit <= 1'b0;
`endif
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2) begin
            rx_div   <= divider;
            rx_cnt   <= {1'b0, divider[15:1]} - 16'd1;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_cnt   <= rx_div - 16'd1;
              rx_bit   <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            rx_cnt   <= rx_div - 16'd1;
            if (rx_bit == LAST_BIT) begin
`ifdef UART_BUFFERED_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
`ifdef UART_BUFFERED_PARITY_EN
        RX_PARITY: begin
          if (rx_cnt == '0) begin
            rx_par_bit <= rx_s2;
            rx_cnt     <= rx_div - 16'd1;
            rx_state   <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
`endif
        RX_STOP: begin
          // Leave at the stop-bit centre so the next start edge is not missed.
          if (rx_cnt == '0) rx_state <= RX_IDLE;
          else              rx_cnt   <= rx_cnt - 16'd1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- control registers and flags ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      divider     <= RST_DIV;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_BUFFERED_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      if (wr_div) divider <= (bus.mem_wdata[15:0] < 16'd4) ? 16'd4 : bus.mem_wdata[15:0];
      // Set terms are OR-ed after the clear so a same-cycle event survives W1C.
      overrun     <= (stop_hit && rx_s2 && rx_full && !rx_pop) ||
                     (overrun && !(wr_status && bus.mem_wdata[2]));
      framing_err <= (stop_hit && !rx_s2) ||
                     (framing_err && !(wr_status && bus.mem_wdata[3]));
`ifdef UART_BUFFERED_PARITY_EN
      parity_err  <= (stop_hit && rx_s2 && ((^rx_shift) != rx_par_bit)) ||
                     (parity_err && !(wr_status && bus.mem_wdata[4]));
`endif
    end
  end

  // ---------------- read path ----------------
  logic [31:0] status, rd_val;
  logic        par_flag;

`ifdef UART_BUFFERED_PARITY_EN
  assign par_flag = parity_err;
`else
  assign par_flag = 1'b0;
`endif

  assign status = {26'd0, (!tx_empty || tx_state != TX_IDLE), par_flag,
                   framing_err, overrun, !rx_empty, !tx_full};

  always_comb begin
    rd_val = '0;
    case (off)
      8'h00:   rd_val = status;
      8'h08:   rd_val = rx_empty ? '0 : 32'(rx_head);
      8'h0C:   rd_val = {16'd0, divider};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_ready <= accept;
      bus.mem_rdata <= (accept && !is_wr) ? rd_val : '0;
    end
  end

endmodule
